pf_ddr4_dq_rx_train: RTL and testbench
======================================

# pf_ddr4_dq_rx_train

Fabric-side receive trainer and capture for one DDR4 DQ bit. It sits between the PolarFire IOD RX path (8-bit deserialized RX data, RX_BIT_SLIP, delay-line move, direction and load) and the PHY read datapath. On request it finds word alignment by bit-slipping, sweeps the input delay line to measure the passing eye, and parks the delay at eye centre. Once trained, it forwards captured read data with a valid flag.

## Interface
- DATA_W, 8: deserialized bits per FAB_CLK (4:1 DDR).
- TAP_W, 7: delay-line tap counter width.
- TAP_MAX, 127: highest legal tap.
- TRAIN_PATTERN, 8'h35: expected aligned training word.
- MATCH_CNT, 16: consecutive matching words required for a pass.
- SETTLE_CYC, 8: idle cycles after any slip, move or load before checking.
- MIN_EYE, 4: minimum passing taps for success.

Ports:
- FAB_CLK  in  1  fabric clock; all logic on its rising edge.
- ARST_N  in  1  reset, asynchronous assert, active-low.
- TRAIN_START  in  1  one-cycle request; honoured only in IDLE, DONE or FAIL.
- RX_DATA_IN  in  DATA_W  deserialized word from the IOD.
- DELAY_LINE_OUT_OF_RANGE  in  1  IOD delay-line saturation flag.
- RX_BIT_SLIP  out  1  one-cycle slip pulse to the IOD.
- DELAY_LINE_MOVE  out  1  one-cycle tap step pulse.
- DELAY_LINE_DIRECTION  out  1  1 = increment, 0 = decrement; valid with MOVE.
- DELAY_LINE_LOAD  out  1  one-cycle pulse that reloads tap 0.
- TRAIN_DONE  out  1  level; training succeeded.
- TRAIN_FAIL  out  1  level; training failed.
- TAP_COUNT  out  TAP_W  current tap.
- EYE_FIRST, EYE_LAST  out  TAP_W  first and last passing taps.
- RX_DATA_OUT  out  DATA_W  registered RX_DATA_IN.
- RX_VALID  out  1  high in DONE only.

## Operation
- All outputs are 0 at reset. The state is IDLE, all counters are 0 and `first_found` is 0.
- The state machine has the states IDLE, LOAD, SETTLE, CHECK, SLIP, MOVE, CENTER, DONE and FAIL.
- IDLE / DONE / FAIL + TRAIN_START → LOAD.
  - LOAD pulses DELAY_LINE_LOAD and clears the tap, slip counter, `first_found`, DONE and FAIL.
  - It then goes to SETTLE.
- SETTLE counts SETTLE_CYC cycles, then goes to the state it was armed with: CHECK or CENTER.
- CHECK compares RX_DATA_IN against TRAIN_PATTERN.
  - It passes on MATCH_CNT consecutive matches.
  - It fails at the first mismatch.
- On a pass:
  - If this is the first pass, set EYE_FIRST = tap and `first_found` = 1.
  - Set EYE_LAST = tap.
  - Go to MOVE, incrementing.
- On a fail with `first_found` = 0:
  - If slip_cnt < DATA_W-1: go to SLIP, which pulses RX_BIT_SLIP, increments slip_cnt, then goes to SETTLE.
  - Otherwise: pulse one restoring slip (slip_cnt wraps to 0), then go to MOVE.
- On a fail with `first_found` = 1: the eye has closed; go to CENTER.
- Once `first_found` = 1, no further slips are issued.
- MOVE:
  - If tap == TAP_MAX or DELAY_LINE_OUT_OF_RANGE = 1, do not pulse. Go to CENTER if `first_found`, else to FAIL.
  - Otherwise pulse MOVE with DIRECTION = 1, increment tap, then go to SETTLE.
- CENTER:
  - Target = (EYE_FIRST + EYE_LAST) >> 1, truncated.
  - If EYE_LAST − EYE_FIRST + 1 < MIN_EYE, go to FAIL.
  - Otherwise issue DIRECTION = 0 MOVE pulses, one every 2 cycles, decrementing tap until tap == target.
  - Then wait SETTLE_CYC and go to DONE.
- DONE: TRAIN_DONE = 1, RX_VALID = 1, RX_DATA_OUT = RX_DATA_IN delayed one cycle.
- FAIL: TRAIN_FAIL = 1, RX_VALID = 0; TAP_COUNT holds its value.
- TRAIN_START during LOAD through CENTER is ignored.
- At most one of SLIP, MOVE or LOAD is high in any cycle.

## Timing
- Control pulses are exactly one cycle wide and come from registers.
- Every slip or increment move is followed by SETTLE_CYC + MATCH_CNT cycles (best case) before the next decision.
- RX_DATA_IN → RX_DATA_OUT latency is 1 cycle.
- RX_VALID rises in the same cycle as TRAIN_DONE.
- DONE and FAIL are sticky until the next TRAIN_START.
- ARST_N low mid-training returns every output to 0 immediately. The tap is unknown afterwards, so the next training always begins with LOAD.

## Configuration
- With PF_DDR4_RX_EYE_STATS_EN defined, EYE_FIRST and EYE_LAST are registered outputs holding the measured values.
- Without it, both ports drive 0. The internal first/last registers remain and are used for centring and for the MIN_EYE check.

## Structure
- Package pf_ddr4_rx_train_pkg holds:
  - the state enum;
  - the default TRAIN_PATTERN constant;
  - the tap type, TAP_W wide.
- Sub-module pf_ddr4_rx_pattern_chk contains the MATCH_CNT consecutive-match counter. It has start, data and pattern inputs and pass/fail pulse outputs.

## Test plan
- Reset released, no TRAIN_START → all outputs 0 and zero pulses for 1000 cycles.
- Bench model: pattern rotated by 3 and eye at taps 10–20 → 21 increment moves, 83 slips, 6 decrement moves; TAP_COUNT = 15, EYE_FIRST = 10, EYE_LAST = 20, TRAIN_DONE = 1.
- No tap ever passes → 127 increment moves, then TRAIN_FAIL = 1, RX_VALID = 0.
- Eye at taps 30–31 (MIN_EYE = 4) → TRAIN_FAIL = 1 after the eye closes; no decrement moves.
- DELAY_LINE_OUT_OF_RANGE forced at tap 50 with the eye at 40–60 → CENTER with EYE_LAST = 50; TAP_COUNT = 45; DONE.
- ARST_N pulsed mid-CHECK, then TRAIN_START → the first pulse seen is DELAY_LINE_LOAD, and training completes normally.

Source files
------------

// File: rtl/pf_ddr4_rx_train_pkg.sv
// Shared state encoding, tap type and default training word for the DDR4 DQ receive trainer.
package pf_ddr4_rx_train_pkg;

  localparam int         TAP_W_DEF         = 7;
  localparam logic [7:0] TRAIN_PATTERN_DEF = 8'h35;

  typedef logic [TAP_W_DEF-1:0] tap_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_CHECK,
    ST_SLIP,
    ST_MOVE,
    ST_CENTER,
    ST_DONE,
    ST_FAIL
  } state_t;

endpackage

// File: rtl/pf_ddr4_rx_pattern_chk.sv
// Consecutive-match detector for the training word: start arms it, then one-cycle pass or fail.
module pf_ddr4_rx_pattern_chk
  import pf_ddr4_rx_train_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MATCH_CNT = 16
) (
  input  logic              fab_clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] pattern,
  output logic              pass,
  output logic              fail
);

  localparam int            CW       = (MATCH_CNT > 1) ? $clog2(MATCH_CNT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MATCH_CNT - 1);

  logic          armed;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_cur;

  // start doubles as the first compare cycle, so the count reloads combinationally
  always_comb cnt_cur = start ? CNT_LOAD : cnt;

  always_ff @(posedge fab_clk or negedge arst_n) begin
    if (!arst_n) begin
      armed <= 1'b0;
      cnt   <= '0;
      pass  <= 1'b0;
      fail  <= 1'b0;
    end else begin
      pass <= 1'b0;
      fail <= 1'b0;
      if (start || armed) begin
        if (data != pattern) begin
          fail  <= 1'b1;
          armed <= 1'b0;
        end else if (cnt_cur == '0) begin
          pass  <= 1'b1;
          armed <= 1'b0;
        end else begin
          cnt   <= cnt_cur - CW'(1);
          armed <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pf_ddr4_dq_rx_train.sv
// DDR4 DQ receive trainer: bit-slip word alignment, delay-line eye sweep, eye centring and capture.
// Define PF_DDR4_RX_EYE_STATS_EN to expose the measured eye edges on EYE_FIRST/EYE_LAST.
module pf_ddr4_dq_rx_train
  import pf_ddr4_rx_train_pkg::*;
#(
  parameter int                DATA_W        = 8,
  parameter int                TAP_W         = TAP_W_DEF,
  parameter int                TAP_MAX       = 127,
  parameter logic [DATA_W-1:0] TRAIN_PATTERN = DATA_W'(TRAIN_PATTERN_DEF),
  parameter int                MATCH_CNT     = 16,
  parameter int                SETTLE_CYC    = 8,
  parameter int                MIN_EYE       = 4
) (
  input  logic              FAB_CLK,
  input  logic              ARST_N,
  input  logic              TRAIN_START,
  input  logic [DATA_W-1:0] RX_DATA_IN,
  input  logic              DELAY_LINE_OUT_OF_RANGE,
  output logic              RX_BIT_SLIP,
  output logic              DELAY_LINE_MOVE,
  output logic              DELAY_LINE_DIRECTION,
  output logic              DELAY_LINE_LOAD,
  output logic              TRAIN_DONE,
  output logic              TRAIN_FAIL,
  output logic [TAP_W-1:0]  TAP_COUNT,
  output logic [TAP_W-1:0]  EYE_FIRST,
  output logic [TAP_W-1:0]  EYE_LAST,
  output logic [DATA_W-1:0] RX_DATA_OUT,
  output logic              RX_VALID
);

  // state  | meaning
  // IDLE   | waiting for TRAIN_START after reset
  // LOAD   | reload tap 0, clear alignment and eye bookkeeping
  // SETTLE | let the IOD settle after slip/move/load, then go to settle_next
  // CHECK  | run the consecutive-match checker on the current tap/slip
  // SLIP   | one bit-slip toward word alignment
  // MOVE   | step the delay line up one tap, or end the sweep at the limit
  // CENTER | reject a narrow eye, else walk down to the eye centre
  // DONE   | trained; forward captured data with RX_VALID
  // FAIL   | training failed; tap held

  localparam int               SW          = $clog2(SETTLE_CYC + 1);
  localparam int               SLW         = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE_CYC - 1);
  localparam logic [SLW-1:0]   SLIP_LAST   = SLW'(DATA_W - 1);
  localparam logic [TAP_W-1:0] TAP_TOP     = TAP_W'(TAP_MAX);
  localparam logic [TAP_W:0]   MIN_EYE_W   = (TAP_W + 1)'(MIN_EYE);

  state_t             state;
  state_t             settle_next;
  logic [SW-1:0]      settle_cnt;
  logic [SLW-1:0]     slip_cnt;
  logic [TAP_W-1:0]   tap;
  logic [TAP_W-1:0]   eye_first;
  logic [TAP_W-1:0]   eye_last;
  logic               first_found;
  logic               chk_start;
  logic               chk_pass;
  logic               chk_fail;
  logic               rx_bit_slip;
  logic               delay_line_move;
  logic               delay_line_direction;
  logic               delay_line_load;
  logic               train_done;
  logic               train_fail;
  logic               rx_valid;
  logic [DATA_W-1:0]  rx_data_out;
  logic [TAP_W:0]     eye_sum;
  logic [TAP_W:0]     eye_width;
  logic [TAP_W-1:0]   centre_tap;

  always_comb begin
    eye_sum    = {1'b0, eye_first} + {1'b0, eye_last};
    eye_width  = {1'b0, eye_last} - {1'b0, eye_first} + (TAP_W + 1)'(1);
    centre_tap = TAP_W'(eye_sum >> 1);
  end

  pf_ddr4_rx_pattern_chk #(
    .DATA_W    (DATA_W),
    .MATCH_CNT (MATCH_CNT)
  ) u_pattern_chk (
    .fab_clk (FAB_CLK),
    .arst_n  (ARST_N),
    .start   (chk_start),
    .data    (RX_DATA_IN),
    .pattern (TRAIN_PATTERN),
    .pass    (chk_pass),
    .fail    (chk_fail)
  );

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state                <= ST_IDLE;
      settle_next          <= ST_CHECK;
      settle_cnt           <= '0;
      slip_cnt             <= '0;
      tap                  <= '0;
      eye_first            <= '0;
      eye_last             <= '0;
      first_found          <= 1'b0;
      chk_start            <= 1'b0;
      rx_bit_slip          <= 1'b0;
      delay_line_move      <= 1'b0;
      delay_line_direction <= 1'b0;
      delay_line_load      <= 1'b0;
      train_done           <= 1'b0;
      train_fail           <= 1'b0;
      rx_valid             <= 1'b0;
      rx_data_out          <= '0;
    end else begin
      rx_bit_slip          <= 1'b0;
      delay_line_move      <= 1'b0;
      delay_line_direction <= 1'b0;
      delay_line_load      <= 1'b0;
      chk_start            <= 1'b0;
      rx_data_out          <= '0;
      case (state)
        ST_IDLE: if (TRAIN_START) state <= ST_LOAD;
        ST_LOAD: begin
          delay_line_load <= 1'b1;
          tap             <= '0;
          slip_cnt        <= '0;
          first_found     <= 1'b0;
          eye_first       <= '0;
          eye_last        <= '0;
          train_done      <= 1'b0;
          train_fail      <= 1'b0;
          settle_cnt      <= SETTLE_LOAD;
          settle_next     <= ST_CHECK;
          state           <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt == '0) begin
            state <= settle_next;
            if (settle_next == ST_CHECK) chk_start <= 1'b1;
            if (settle_next == ST_DONE) begin
              train_done  <= 1'b1;
              rx_valid    <= 1'b1;
              rx_data_out <= RX_DATA_IN;
            end
          end else begin
            settle_cnt <= settle_cnt - SW'(1);
          end
        end
        ST_CHECK: begin
          if (chk_pass) begin
            if (!first_found) begin
              eye_first   <= tap;
              first_found <= 1'b1;
            end
            eye_last <= tap;
            state    <= ST_MOVE;
          end else if (chk_fail) begin
            if (first_found) begin
              state <= ST_CENTER;
            end else if (slip_cnt < SLIP_LAST) begin
              state <= ST_SLIP;
            end else begin
              // all phases tried at this tap: one more slip returns the IOD to its start phase
              rx_bit_slip <= 1'b1;
              slip_cnt    <= '0;
              state       <= ST_MOVE;
            end
          end
        end
        ST_SLIP: begin
          rx_bit_slip <= 1'b1;
          slip_cnt    <= slip_cnt + SLW'(1);
          settle_cnt  <= SETTLE_LOAD;
          settle_next <= ST_CHECK;
          state       <= ST_SETTLE;
        end
        ST_MOVE: begin
          if (tap == TAP_TOP || DELAY_LINE_OUT_OF_RANGE) begin
            if (first_found) begin
              state <= ST_CENTER;
            end else begin
              train_fail <= 1'b1;
              state      <= ST_FAIL;
            end
          end else begin
            delay_line_move      <= 1'b1;
            delay_line_direction <= 1'b1;
            tap                  <= tap + TAP_W'(1);
            settle_cnt           <= SETTLE_LOAD;
            settle_next          <= ST_CHECK;
            state                <= ST_SETTLE;
          end
        end
        ST_CENTER: begin
          if (eye_width < MIN_EYE_W) begin
            train_fail <= 1'b1;
            state      <= ST_FAIL;
          end else if (tap == centre_tap) begin
            settle_cnt  <= SETTLE_LOAD;
            settle_next <= ST_DONE;
            state       <= ST_SETTLE;
          end else if (!delay_line_move) begin
            delay_line_move <= 1'b1;
            tap             <= tap - TAP_W'(1);
          end
        end
        ST_DONE: begin
          if (TRAIN_START) begin
            train_done <= 1'b0;
            rx_valid   <= 1'b0;
            state      <= ST_LOAD;
          end else begin
            rx_data_out <= RX_DATA_IN;
          end
        end
        ST_FAIL: begin
          if (TRAIN_START) begin
            train_fail <= 1'b0;
            state      <= ST_LOAD;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign RX_BIT_SLIP          = rx_bit_slip;
  assign DELAY_LINE_MOVE      = delay_line_move;
  assign DELAY_LINE_DIRECTION = delay_line_direction;
  assign DELAY_LINE_LOAD      = delay_line_load;
  assign TRAIN_DONE           = train_done;
  assign TRAIN_FAIL           = train_fail;
  assign TAP_COUNT            = tap;
  assign RX_DATA_OUT          = rx_data_out;
  assign RX_VALID             = rx_valid;

`ifdef PF_DDR4_RX_EYE_STATS_EN
  assign EYE_FIRST = eye_first;
  assign EYE_LAST  = eye_last;
`else
  assign EYE_FIRST = '0;
  assign EYE_LAST  = '0;
`endif

endmodule

// File: tb/tb_pf_ddr4_dq_rx_train.sv
// Directed bench for pf_ddr4_dq_rx_train with a behavioural IOD: bit-slip phase, delay tap and eye window.
module tb_pf_ddr4_dq_rx_train;
  import pf_ddr4_rx_train_pkg::*;

  localparam logic [7:0] PAT = 8'h35;
`ifdef PF_DDR4_RX_EYE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       FAB_CLK = 1'b0;
  logic       ARST_N  = 1'b1;
  logic       TRAIN_START = 1'b0;
  logic [7:0] RX_DATA_IN = 8'h00;
  logic       DELAY_LINE_OUT_OF_RANGE = 1'b0;
  logic       RX_BIT_SLIP, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD;
  logic       TRAIN_DONE, TRAIN_FAIL, RX_VALID;
  tap_t       TAP_COUNT, EYE_FIRST, EYE_LAST;
  logic [7:0] RX_DATA_OUT;

  pf_ddr4_dq_rx_train dut (
    .FAB_CLK                 (FAB_CLK),
    .ARST_N                  (ARST_N),
    .TRAIN_START             (TRAIN_START),
    .RX_DATA_IN              (RX_DATA_IN),
    .DELAY_LINE_OUT_OF_RANGE (DELAY_LINE_OUT_OF_RANGE),
    .RX_BIT_SLIP             (RX_BIT_SLIP),
    .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
    .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
    .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
    .TRAIN_DONE              (TRAIN_DONE),
    .TRAIN_FAIL              (TRAIN_FAIL),
    .TAP_COUNT               (TAP_COUNT),
    .EYE_FIRST               (EYE_FIRST),
    .EYE_LAST                (EYE_LAST),
    .RX_DATA_OUT             (RX_DATA_OUT),
    .RX_VALID                (RX_VALID)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  int n_checks = 0;
  int n_errors = 0;

  // IOD model state and pulse statistics
  int m_tap = 0, m_slip = 0;
  int eye_lo = 10, eye_hi = 20, oor_tap = -1, rot = 3;
  int n_inc = 0, n_dec = 0, n_slip = 0, n_load = 0;
  int n_multi = 0, n_wide = 0, n_valid_bad = 0, first_pulse = 0;
  bit p_slip = 0, p_move = 0, p_load = 0, free_data = 0;
  logic [7:0] last_drv = 8'h00, prev_drv = 8'h00;
  int wait_cnt, idle_bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
    logic [15:0] w;
    w = {v, v} << k;
    return w[15:8];
  endfunction

  function automatic logic outs_zero();
    return ({RX_BIT_SLIP, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD,
             TRAIN_DONE, TRAIN_FAIL, TAP_COUNT, EYE_FIRST, EYE_LAST,
             RX_DATA_OUT, RX_VALID} === '0);
  endfunction

  task automatic drive();
    int k;
    if (free_data) begin
      RX_DATA_IN = 8'($urandom);
    end else if (m_tap >= eye_lo && m_tap <= eye_hi) begin
      k = (rot - m_slip + 8) % 8;
      RX_DATA_IN = rotl8(PAT, k);
    end else begin
      RX_DATA_IN = ~PAT;
    end
    last_drv = RX_DATA_IN;
    DELAY_LINE_OUT_OF_RANGE = (oor_tap >= 0) && (m_tap >= oor_tap);
  endtask

  // advance to the next falling edge, react to the DUT's pulses, then drive the IOD outputs
  task automatic step();
    int np;
    @(negedge FAB_CLK);
    np = int'(RX_BIT_SLIP) + int'(DELAY_LINE_MOVE) + int'(DELAY_LINE_LOAD);
    if (np > 1) n_multi++;
    if ((RX_BIT_SLIP && p_slip) || (DELAY_LINE_MOVE && p_move) || (DELAY_LINE_LOAD && p_load))
      n_wide++;
    p_slip = RX_BIT_SLIP;
    p_move = DELAY_LINE_MOVE;
    p_load = DELAY_LINE_LOAD;
    if (first_pulse == 0) begin
      if (DELAY_LINE_LOAD)      first_pulse = 1;
      else if (RX_BIT_SLIP)     first_pulse = 2;
      else if (DELAY_LINE_MOVE) first_pulse = 3;
    end
    if (DELAY_LINE_LOAD) begin m_tap = 0; n_load++; end
    if (RX_BIT_SLIP) begin m_slip = (m_slip + 1) % 8; n_slip++; end
    if (DELAY_LINE_MOVE) begin
      if (DELAY_LINE_DIRECTION) begin m_tap++; n_inc++; end
      else begin m_tap--; n_dec++; end
    end
    if (RX_VALID && !TRAIN_DONE) n_valid_bad++;
    prev_drv = last_drv;
    drive();
  endtask

  task automatic run_train(input int lo, input int hi, input int oor, input int budget,
                           input int ignore_at, input string tag);
    eye_lo = lo; eye_hi = hi; oor_tap = oor; m_slip = 0;
    n_inc = 0; n_dec = 0; n_slip = 0; n_load = 0; first_pulse = 0;
    TRAIN_START = 1'b1;
    step();
    TRAIN_START = 1'b0;
    wait_cnt = 0;
    while (!(TRAIN_DONE || TRAIN_FAIL) && wait_cnt < budget) begin
      step();
      wait_cnt++;
      if (wait_cnt == ignore_at) begin
        TRAIN_START = 1'b1;
        step();
        TRAIN_START = 1'b0;
        wait_cnt++;
      end
    end
    check({tag, ".in_time"}, 32'(wait_cnt < budget), 1);
  endtask

  task automatic check_run(input string tag, input int inc, input int slips, input int dec,
                           input int tapv, input int ef, input int el, input bit done);
    check({tag, ".inc_moves"}, n_inc, inc);
    check({tag, ".slips"}, n_slip, slips);
    check({tag, ".dec_moves"}, n_dec, dec);
    check({tag, ".loads"}, n_load, 1);
    check({tag, ".tap"}, 32'(TAP_COUNT), tapv);
    check({tag, ".model_tap"}, m_tap, tapv);
    check({tag, ".eye_first"}, 32'(EYE_FIRST), STATS ? ef : 0);
    check({tag, ".eye_last"}, 32'(EYE_LAST), STATS ? el : 0);
    check({tag, ".done"}, 32'(TRAIN_DONE), 32'(done));
    check({tag, ".fail"}, 32'(TRAIN_FAIL), 32'(!done));
    check({tag, ".valid"}, 32'(RX_VALID), 32'(done));
  endtask

  initial begin
    drive();
    #1 ARST_N = 1'b0;
    repeat (3) step();
    check("reset.outs_zero", 32'(outs_zero()), 1);
    ARST_N = 1'b1;

    idle_bad = 0;
    repeat (1000) begin
      step();
      if (!outs_zero()) idle_bad++;
    end
    check("idle.nonzero_cycles", idle_bad, 0);
    check("idle.pulses", n_inc + n_dec + n_slip + n_load, 0);

    // rotated by 3, eye 10..20, plus an ignored TRAIN_START mid-training
    run_train(10, 20, -1, 20000, 300, "eye10_20");
    check_run("eye10_20", 21, 83, 6, 15, 10, 20, 1'b1);
    check("eye10_20.first_pulse", first_pulse, 1);

    free_data = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("done.data_latency", 32'(RX_DATA_OUT), 32'(prev_drv));
    end
    free_data = 1'b0;
    repeat (50) step();
    check("done.sticky", 32'(TRAIN_DONE), 1);

    run_train(1000, -1, -1, 20000, 0, "no_eye");
    check_run("no_eye", 127, 1024, 0, 127, 0, 0, 1'b0);
    repeat (30) step();
    check("fail.sticky", 32'(TRAIN_FAIL), 1);
    check("fail.tap_hold", 32'(TAP_COUNT), 127);

    run_train(30, 31, -1, 20000, 0, "narrow");
    check_run("narrow", 32, 243, 0, 32, 30, 31, 1'b0);

    run_train(40, 60, 50, 20000, 0, "oor50");
    check_run("oor50", 50, 323, 5, 45, 40, 50, 1'b1);

    // asynchronous reset in the middle of a CHECK, then a fresh training
    eye_lo = 10; eye_hi = 20; oor_tap = -1; m_slip = 0; n_slip = 0;
    TRAIN_START = 1'b1;
    step();
    TRAIN_START = 1'b0;
    wait_cnt = 0;
    while (n_slip < 5 && wait_cnt < 5000) begin
      step();
      wait_cnt++;
    end
    check("rst_mid.reached", 32'(n_slip >= 5), 1);
    repeat (9) step();
    #2 ARST_N = 1'b0;
    #1 check("rst_mid.async_zero", 32'(outs_zero()), 1);
    step();
    ARST_N = 1'b1;
    repeat (5) step();
    check("rst_mid.idle_zero", 32'(outs_zero()), 1);
    run_train(10, 20, -1, 20000, 0, "retrain");
    check("retrain.first_pulse", first_pulse, 1);
    check_run("retrain", 21, 83, 6, 15, 10, 20, 1'b1);

    check("global.one_pulse_per_cycle", n_multi, 0);
    check("global.pulse_width", n_wide, 0);
    check("global.valid_without_done", n_valid_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
